cpu_trace_capture: RTL
======================

// Module: cpu_trace_capture
// PURPOSE
//  Consumer of the SingleCycleCPU observation outputs (PC, instruction, ALU result, write data).
//  Captures one record per executed instruction into an on-chip FIFO.
//  Streams each record out as 32-bit words over a valid/ready port.
//  Sits beside the CPU and replaces waveform inspection with a checkable trace stream.
// PARAMETERS
//  DEPTH   16   records held in the FIFO; must be a power of 2, >= 2
//  CNT_W   16   width of the saturating drop counter
// PORTS
//  clk            in   1        system clock, rising edge
//  reset          in   1        asynchronous, active-high reset
//  clear          in   1        synchronous flush of FIFO and status
//  cap_en         in   1        global capture enable
//  pc_wre         in   1        capture strobe (CPU PCWre): instruction retires this cycle
//  pc_in          in   32       current PC (CPU _PcOut)
//  instr_in       in   32       current instruction (CPU _instruction)
//  alu_result_in  in   32       ALU result (CPU _ALUResult)
//  write_data_in  in   32       register-file write data (CPU _WriteData)
//  out_data       out  32       trace word
//  out_valid      out  1        out_data holds a valid word
//  out_ready      in   1        sink accepts the word when out_valid && out_ready
//  out_last       out  1        high on the final word of a record
//  out_word_idx   out  3        index of the word within its record
//  level          out  log2(DEPTH)+1  number of records held in the FIFO
//  overflow       out  1        sticky: at least one record was dropped
//  drop_count     out  CNT_W    number of dropped records; saturates at all-ones
// BEHAVIOUR
//  Reset
//   - Async, active-high; all outputs are 0 during and after reset.
//   - FIFO is empty, FSM is IDLE, timestamp counter is 0.
//   - Reset mid-record aborts the record; no partial record resumes.
//  Capture
//   - At each rising edge with cap_en && pc_wre && !clear, push {pc, instr, alu, wdata}.
//   - The values pushed are the input values sampled at that edge.
//  Full
//   - A push is accepted when the FIFO is not full.
//   - When full, a push is also accepted if a record pops at the same edge.
//   - Otherwise the push is dropped: overflow <= 1 and drop_count++ (saturating).
//  Output FSM (states IDLE and SEND)
//   - IDLE -> SEND when the FIFO is not empty. out_valid rises the cycle after the first push:
//     a push at edge N gives out_valid=1 in the cycle after edge N.
//   - SEND emits words in order: idx0 PC, idx1 INSTR, idx2 ALU, idx3 WDATA.
//   - A word advances only on out_valid && out_ready.
//   - While out_valid && !out_ready, out_data, out_word_idx and out_last hold stable.
//   - The record pops on acceptance of its last word.
//   - After the pop, the FSM goes to SEND for the next record if one is present, else IDLE.
//     There are no bubble cycles between back-to-back records.
//  Level
//   - level reflects pushes and pops registered at the same edge.
//   - A simultaneous push and pop leaves level unchanged.
//  Clear
//   - Empties the FIFO, returns the FSM to IDLE, and zeroes overflow, drop_count and the timestamp.
//   - out_valid is 0 the cycle after clear.
//   - clear takes priority over capture at the same edge.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined
//   - A free-running 32-bit cycle counter runs; it wraps from 0xFFFFFFFF to 0.
//   - Each record carries a 5th word, idx4: the counter value at the capture edge.
//   - out_last is asserted on idx4.
//  TRACE_TIMESTAMP_EN undefined
//   - There is no counter; records are 4 words and out_last is on idx3.
// STRUCTURE
//  - cpu_trace_defs.vh (shared header):
//    - word-index constants TRC_IDX_PC/INSTR/ALU/WDATA/TS
//    - FSM state encodings
//    - record width TRC_REC_W (128, or 160 with the timestamp)
//  - Sub-module trace_fifo: synchronous FIFO, DEPTH x TRC_REC_W, with push/pop/full/empty/level.
//    Pointers are one bit wider than the address.
//  - The top level holds the capture logic, drop accounting, the timestamp and the serializer FSM.
// TESTING
//  1. Single record, out_ready=1: push pc=0x00000004, instr=0x02324020
//     -> next 4 cycles out_data = 0x04, 0x02324020, alu, wdata; out_last only on idx3.
//  2. Backpressure: out_ready low for 5 cycles on idx1 -> out_data stays 0x02324020,
//     out_word_idx=1 throughout; resumes on ready.
//  3. Overflow, DEPTH=16, out_ready=0, 20 pushes -> level=16, overflow=1, drop_count=4;
//     the first 16 records drain in order.
//  4. Full plus simultaneous pop: at level=16, accept the last word while pushing
//     -> level stays 16, drop_count unchanged.
//  5. Clear and reset mid-record: assert clear at idx2 -> out_valid=0 next cycle, level=0,
//     overflow=0. Async reset pulse between edges -> all outputs 0 immediately.
//  6. TRACE_TIMESTAMP_EN: pushes at cycles 3 and 7 after reset -> idx4 = 3 and 7, out_last on idx4.

Source files
------------

// File: rtl/cpu_trace_capture_pkg.sv
// Trace record layout, word indices and serializer states shared by the capture block.
// TRACE_TIMESTAMP_EN adds a 32-bit capture timestamp as a fifth record word.
package cpu_trace_capture_pkg;

  localparam logic [2:0] TRC_IDX_PC    = 3'd0;
  localparam logic [2:0] TRC_IDX_INSTR = 3'd1;
  localparam logic [2:0] TRC_IDX_ALU   = 3'd2;
  localparam logic [2:0] TRC_IDX_WDATA = 3'd3;
  localparam logic [2:0] TRC_IDX_TS    = 3'd4;

`ifdef TRACE_TIMESTAMP_EN
  localparam int         TRC_REC_W    = 160;
  localparam logic [2:0] TRC_IDX_LAST = TRC_IDX_TS;
`else
  localparam int         TRC_REC_W    = 128;
  localparam logic [2:0] TRC_IDX_LAST = TRC_IDX_WDATA;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } trc_state_e;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif
    logic [31:0] wdata;
    logic [31:0] alu;
    logic [31:0] instr;
    logic [31:0] pc;
  } trc_rec_t;

  function automatic logic [31:0] trc_word(input trc_rec_t rec, input logic [2:0] idx);
    logic [31:0] w_word;
    case (idx)
      TRC_IDX_PC:    w_word = rec.pc;
      TRC_IDX_INSTR: w_word = rec.instr;
      TRC_IDX_ALU:   w_word = rec.alu;
      TRC_IDX_WDATA: w_word = rec.wdata;
`ifdef TRACE_TIMESTAMP_EN
      TRC_IDX_TS:    w_word = rec.ts;
`endif
      default:       w_word = '0;
    endcase
    return w_word;
  endfunction

endpackage

// File: rtl/cpu_trace_capture_fifo.sv
// Synchronous show-ahead FIFO, DEPTH x W; head visible combinationally, push/pop take effect at the edge.
// Caller must not push when full (unless popping) or pop when empty; i_clear empties it synchronously.
module cpu_trace_capture_fifo #(
  parameter int  DEPTH = 16,
  parameter int  W     = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wr_dat,
  output logic [W-1:0] o_rd_dat,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_level
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[r_rd_ptr[AW-1:0]];
  assign o_level  = r_wr_ptr - r_rd_ptr;
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/cpu_trace_capture.sv
// Captures one CPU record per retired instruction and streams it as 32-bit words; out_valid follows a push by one cycle.
// Words hold under backpressure; records arriving with a full FIFO are dropped and counted. TRACE_TIMESTAMP_EN adds word 4.
module cpu_trace_capture
  import cpu_trace_capture_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  CNT_W = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             cap_en,
  input  logic             pc_wre,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      alu_result_in,
  input  logic [31:0]      write_data_in,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [2:0]       out_word_idx,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count
);

  trc_state_e           r_state;
  logic [2:0]           r_idx;
  logic                 r_overflow;
  logic [CNT_W-1:0]     r_drop_count;
  logic                 w_cap;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_full;
  logic                 w_empty;
  logic [LVL_W-1:0]     w_level;
  trc_rec_t             w_wr_rec;
  trc_rec_t             w_head;
  logic [TRC_REC_W-1:0] w_head_dat;

  assign w_cap     = cap_en && pc_wre && !clear;
  assign w_pop     = (r_state == ST_SEND) && out_ready && (r_idx == TRC_IDX_LAST) && !clear;
  assign w_push_ok = w_cap && (!w_full || w_pop);

  assign w_wr_rec.pc    = pc_in;
  assign w_wr_rec.instr = instr_in;
  assign w_wr_rec.alu   = alu_result_in;
  assign w_wr_rec.wdata = write_data_in;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] r_ts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_ts <= '0;
    else if (clear) r_ts <= '0;
    else            r_ts <= r_ts + 32'd1;
  end

  assign w_wr_rec.ts = r_ts;
`endif

  cpu_trace_capture_fifo #(
    .DEPTH (DEPTH),
    .W     (TRC_REC_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (clear),
    .i_push   (w_push_ok),
    .i_pop    (w_pop),
    .i_wr_dat (w_wr_rec),
    .o_rd_dat (w_head_dat),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (w_level)
  );

  assign w_head = trc_rec_t'(w_head_dat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_cap && !w_push_ok) begin
      r_overflow <= 1'b1;
      if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
    end
  end

  // Entering SEND on the push edge itself is what makes out_valid appear one cycle after capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= TRC_IDX_PC;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_idx   <= TRC_IDX_PC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push_ok || !w_empty) begin
            r_state <= ST_SEND;
            r_idx   <= TRC_IDX_PC;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (r_idx == TRC_IDX_LAST) begin
              r_idx <= TRC_IDX_PC;
              if ((w_level == LVL_W'(1)) && !w_push_ok) r_state <= ST_IDLE;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
      endcase
    end
  end

  assign out_valid    = (r_state == ST_SEND);
  assign out_data     = out_valid ? trc_word(w_head, r_idx) : 32'd0;
  assign out_last     = out_valid && (r_idx == TRC_IDX_LAST);
  assign out_word_idx = r_idx;
  assign level        = w_level;
  assign overflow     = r_overflow;
  assign drop_count   = r_drop_count;

endmodule
